fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the program counter and sequences the combinational instruction memory (64-bit address in, 32-bit word out, word-indexed, DEPTH entries).
- Issues one fetch per cycle, registers each returned word together with its PC into a small output queue, and hands entries to decode over a valid/ready handshake.
- Handles start, halt, branch/jump redirect with flush, and out-of-range or misaligned PC faults.

Parameters:
- XLEN, 64, PC and address width.
- DEPTH, 32, number of instruction-memory words; legal word index is 0..DEPTH-1.
- RESET_PC, 0, byte PC loaded on start; must be 4-byte aligned.
- QDEPTH, 2, output queue entries; minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begin fetching at RESET_PC.
- halt_req  in  1  stop issuing, drain queue, return to idle.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_pc  in  XLEN  byte target PC.
- imem_addr  out  XLEN  word index to instruction memory, equal to pc>>2 zero-extended, registered.
- imem_instr  in  32  word returned by instruction memory for imem_addr.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  XLEN  byte PC of head.
- busy  out  1  state is not IDLE.
- fault  out  1  sticky fault flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, pc=RESET_PC, imem_addr=0, in-flight=0, queue empty.
  - out_valid=0, out_instr=0, out_pc=0, busy=0, fault=0.
- States:
  - IDLE: start moves to RUN and sets pc=RESET_PC. Clears fault.
  - RUN: issues fetches as described below.
  - DRAIN: issues nothing, drops any in-flight word, and moves to IDLE when the queue is empty.
  - FAULT: issues nothing; the queue still drains; fault=1. start moves to RUN with pc=RESET_PC and clears fault.
- Issue (RUN only):
  - Condition: (count - pop + inflight) < QDEPTH, where pop = out_valid & out_ready.
  - On issue: imem_addr<=pc>>2, req_pc<=pc, inflight<=1, pc<=pc+4 (modulo 2^XLEN).
  - No issue that cycle: inflight<=0.
- Capture: when inflight=1 at an edge, {imem_instr, req_pc} is pushed to the queue tail at that edge.
  - Memory latency is one cycle: the address is registered and the word is sampled on the next edge.
- Latency: start sampled at edge E0 -> first imem_addr after E1 -> out_valid=1 after E2. With out_ready held high, steady throughput is 1 instruction/cycle.
- Queue: FIFO ordered. Push and pop in the same cycle are both legal, including when full and when empty (bypass not required; an empty queue means out_valid=0 that cycle). Overflow is impossible by construction of the issue rule.
- Redirect (RUN only; ignored in IDLE, DRAIN and FAULT):
  - Flushes queue and in-flight word at the same edge; out_valid=0 next cycle.
  - pc<=redirect_pc.
  - First fetch of the target issues on the following edge, so the first target instruction is valid 2 cycles after redirect is sampled.
  - A pop in the redirect cycle still counts as accepted; the head is discarded by the flush.
- Priority in the same cycle: redirect > halt_req > issue. redirect and halt_req together apply the redirect's flush, then go to DRAIN.
- halt_req in RUN: goes to DRAIN. The in-flight word is dropped; queued entries remain deliverable.
- Faults, checked before issue in RUN:
  - pc[1:0]!=0, or (pc>>2)>=DEPTH: no issue, state=FAULT, fault=1.
  - Earlier queued entries still deliver.
- start while busy: ignored, except in FAULT.
- rst_n asserted mid-operation: immediate return to reset values; no partial output.

Test Plan:
- Reset, start, out_ready=1; mem[0..3]=0x00000013,0x00100093,0x00200113,0x00300193 -> out_valid high 2 cycles after start; pairs (instr,pc) (0x00000013,0), (0x00100093,4), (0x00200113,8), (0x00300193,12) on consecutive cycles; imem_addr sequence 0,1,2,3.
- Backpressure: out_ready=0 for 5 cycles after the first valid -> queue holds 2 entries, issue stops, imem_addr frozen. Release -> pcs 0,4,8,12 in order with no loss or duplication.
- Redirect to 0x40 while pc 8 is queued -> queued and in-flight entries discarded; next delivered pc=0x40 with instr=mem[16], valid 2 cycles after redirect.
- Run to pc=0x7C (word 31), then next pc=0x80 -> word 31 delivered, fault=1, state FAULT, no imem_addr change. start -> fault=0 and fetch from pc 0.
- Redirect to 0x42 -> FAULT, fault=1. Redirect and halt_req together -> flush, DRAIN, then IDLE (busy=0) with nothing delivered.
- rst_n low for 1 cycle mid-stream with the queue full -> out_valid=0, busy=0, imem_addr=0 immediately; no output until the next start.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : Bundles the fetch sequencer's control inputs, instruction
//                memory bus and decode-side valid/ready handshake.
//                The sequencer drives the master modport; the environment
//                (memory, execute, decode) uses the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
    parameter int XLEN = 64
);
    // Control from the pipeline
    logic            start;
    logic            halt_req;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    // Instruction memory bus (word-indexed address, combinational read)
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_instr;

    // Decode handshake
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;

    // Status
    logic            busy;
    logic            fault;

    modport master (
        input  start,
        input  halt_req,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_instr,
        input  out_ready,
        output imem_addr,
        output out_valid,
        output out_instr,
        output out_pc,
        output busy,
        output fault
    );

    modport slave (
        output start,
        output halt_req,
        output redirect_valid,
        output redirect_pc,
        output imem_instr,
        output out_ready,
        input  imem_addr,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  busy,
        input  fault
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Program-counter owner for a simple in-order front end.
//                Issues one fetch per cycle to a one-cycle-latency
//                instruction memory, queues returned words with their PC and
//                hands them to decode over valid/ready. Supports start, halt
//                (drain), redirect with flush and PC range/alignment faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fetch_sequencer_if.master  sq
);

    localparam int              c_PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int              c_CNT_W = $clog2(QDEPTH + 1);
    localparam int              c_OCC_W = c_CNT_W + 1;
    localparam logic [XLEN-1:0] c_DEPTH = XLEN'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_req_pc;
    logic                r_inflight;
    logic [XLEN-1:0]     r_imem_addr;
    logic                r_fault;

    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [c_CNT_W-1:0]  r_count;
    logic [31:0]         r_q_instr [QDEPTH];
    logic [XLEN-1:0]     r_q_pc    [QDEPTH];

    // ------------------------------------------------------------------
    // Per-cycle decisions
    // ------------------------------------------------------------------
    state_t              w_state_nxt;
    logic                w_issue;
    logic                w_fault_set;
    logic                w_start_run;

    logic                w_in_run;
    logic                w_valid;
    logic                w_pop;
    logic                w_redirect;
    logic                w_halt;
    logic                w_push;
    logic                w_pc_bad;
    logic [c_OCC_W-1:0]  w_occ;
    logic                w_has_room;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_in_run   = (r_state == S_RUN);
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid & sq.out_ready;
    // Redirect and halt only have meaning while fetching.
    assign w_redirect = w_in_run & sq.redirect_valid;
    assign w_halt     = w_in_run & sq.halt_req;
    // The returning word is discarded whenever the stream is cut this cycle.
    assign w_push     = r_inflight & ~w_redirect & ~w_halt;
    assign w_pc_bad   = (r_pc[1:0] != 2'b00) || ((r_pc >> 2) >= c_DEPTH);
    // Occupancy seen after this edge: queued, minus the accepted head, plus
    // the word arriving now. A new fetch is only launched if it fits, which
    // is what makes queue overflow impossible.
    assign w_occ      = {1'b0, r_count} - c_OCC_W'(w_pop) + c_OCC_W'(r_inflight);
    assign w_has_room = (w_occ < c_OCC_W'(QDEPTH));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and issue decision; redirect beats halt beats fault beats issue
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_fault_set = 1'b0;
        w_start_run = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sq.start) begin
                    w_state_nxt = S_RUN;
                    w_start_run = 1'b1;
                end
            end
            S_RUN: begin
                if (w_redirect) begin
                    w_state_nxt = sq.halt_req ? S_DRAIN : S_RUN;
                end else if (w_halt) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_pc_bad) begin
                    w_state_nxt = S_FAULT;
                    w_fault_set = 1'b1;
                end else if (w_has_room) begin
                    w_issue = 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_count == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FAULT: begin
                if (sq.start) begin
                    w_state_nxt = S_RUN;
                    w_start_run = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Program counter, memory request and sticky fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_req_pc    <= '0;
            r_inflight  <= 1'b0;
            r_imem_addr <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_inflight <= w_issue;

            if (w_start_run) begin
                r_pc <= RESET_PC;
            end else if (w_redirect) begin
                r_pc <= sq.redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + XLEN'(4);
            end

            if (w_issue) begin
                r_imem_addr <= r_pc >> 2;
                r_req_pc    <= r_pc;
            end

            if (w_fault_set) begin
                r_fault <= 1'b1;
            end else if (w_start_run || (r_state == S_IDLE)) begin
                r_fault <= 1'b0;
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_redirect) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= f_ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= f_ptr_inc(r_head);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Queue storage; contents are only observable through a valid head
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_tail] <= sq.imem_instr;
            r_q_pc[r_tail]    <= r_req_pc;
        end
    end

    // Outputs: head fields are forced to zero whenever nothing is offered
    assign sq.imem_addr = r_imem_addr;
    assign sq.out_valid = w_valid;
    assign sq.out_instr = w_valid ? r_q_instr[r_head] : 32'h0;
    assign sq.out_pc    = w_valid ? r_q_pc[r_head]    : '0;
    assign sq.busy      = (r_state != S_IDLE);
    assign sq.fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. A transaction-level
//                model predicts the delivered (instr, pc) stream into a
//                scoreboard queue; a monitor pops it on each accepted head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int          XLEN   = 64;
    localparam int          DEPTH  = 32;
    localparam int          QDEPTH = 2;
    localparam logic [63:0] RST_PC = 64'h0;

    localparam int MD_IDLE  = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_DRAIN = 2;
    localparam int MD_FAULT = 3;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    logic clk;
    logic rst_n;
    logic [31:0] mem [DEPTH];

    fetch_sequencer_if #(.XLEN(XLEN)) sif ();

    fetch_sequencer #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sq    (sif.master)
    );

    assign sif.imem_instr = (sif.imem_addr < 64'(DEPTH)) ? mem[sif.imem_addr[4:0]] : 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: fetch mode, pc, one outstanding request and the
    // expected delivery queue (which doubles as the scoreboard).
    // ------------------------------------------------------------------
    int          m_mode     = MD_IDLE;
    logic [63:0] m_pc       = RST_PC;
    logic [63:0] m_req_pc   = 64'h0;
    logic [63:0] m_addr     = 64'h0;
    bit          m_inflight = 1'b0;
    bit          m_fault    = 1'b0;
    int          m_pre      = 0;
    ent_t        exp_q[$];

    bit   mr_run, mr_rd, mr_hl, mr_issue;
    ent_t mr_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode     = MD_IDLE;
            m_pc       = RST_PC;
            m_req_pc   = 64'h0;
            m_addr     = 64'h0;
            m_inflight = 1'b0;
            m_fault    = 1'b0;
            m_pre      = 0;
            exp_q.delete();
        end else begin
            mr_run   = (m_mode == MD_RUN);
            mr_rd    = mr_run && sif.redirect_valid;
            mr_hl    = mr_run && sif.halt_req;
            mr_issue = 1'b0;
            if (m_inflight && !mr_rd && !mr_hl) begin
                mr_e.instr = mem[m_req_pc[6:2]];
                mr_e.pc    = m_req_pc;
                exp_q.push_back(mr_e);
            end
            case (m_mode)
                MD_IDLE, MD_FAULT: begin
                    if (sif.start) begin
                        m_mode  = MD_RUN;
                        m_pc    = RST_PC;
                        m_fault = 1'b0;
                    end
                end
                MD_RUN: begin
                    if (mr_rd) begin
                        exp_q.delete();
                        m_pc   = sif.redirect_pc;
                        m_mode = sif.halt_req ? MD_DRAIN : MD_RUN;
                    end else if (mr_hl) begin
                        m_mode = MD_DRAIN;
                    end else if (m_pc % 4 != 0 || m_pc / 4 >= 64'(DEPTH)) begin
                        m_mode  = MD_FAULT;
                        m_fault = 1'b1;
                    end else if (exp_q.size() < QDEPTH) begin
                        m_addr   = m_pc / 4;
                        m_req_pc = m_pc;
                        m_pc     = m_pc + 64'd4;
                        mr_issue = 1'b1;
                    end
                end
                default: begin
                    if (m_pre == 0) m_mode = MD_IDLE;
                end
            endcase
            m_inflight = mr_issue;
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on accept
    ent_t mon_e;
    always @(negedge clk) begin
        m_pre = exp_q.size();
        chk("out_valid", 64'(sif.out_valid), 64'(m_pre != 0));
        chk("busy",      64'(sif.busy),      64'(m_mode != MD_IDLE));
        chk("fault",     64'(sif.fault),     64'(m_fault));
        chk("imem_addr", sif.imem_addr,      m_addr);
        if (m_pre != 0 && sif.out_ready) begin
            mon_e = exp_q.pop_front();
            chk("out_instr", 64'(sif.out_instr), 64'(mon_e.instr));
            chk("out_pc",    sif.out_pc,         mon_e.pc);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        sif.start = 1'b1;
        cyc(1);
        sif.start = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] tgt, input bit with_halt);
        sif.redirect_valid = 1'b1;
        sif.redirect_pc    = tgt;
        sif.halt_req       = with_halt;
        cyc(1);
        sif.redirect_valid = 1'b0;
        sif.halt_req       = 1'b0;
    endtask

    int r, s, w;

    initial begin
        rst_n              = 1'b0;
        sif.start          = 1'b0;
        sif.halt_req       = 1'b0;
        sif.redirect_valid = 1'b0;
        sif.redirect_pc    = 64'h0;
        sif.out_ready      = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h00000013;
        mem[1] = 32'h00100093;
        mem[2] = 32'h00200113;
        mem[3] = 32'h00300193;

        // Reset values
        cyc(3);
        chk("rst_out_valid", 64'(sif.out_valid), 64'd0);
        chk("rst_busy",      64'(sif.busy),      64'd0);
        chk("rst_fault",     64'(sif.fault),     64'd0);
        chk("rst_imem_addr", sif.imem_addr,      64'd0);
        chk("rst_out_instr", 64'(sif.out_instr), 64'd0);
        chk("rst_out_pc",    sif.out_pc,         64'd0);
        rst_n = 1'b1;
        cyc(1);

        // Start: first word valid two edges after start is sampled
        pulse_start();
        cyc(1);
        chk("start_not_yet_valid", 64'(sif.out_valid), 64'd0);
        cyc(1);
        chk("first_valid",  64'(sif.out_valid), 64'd1);
        chk("first_instr",  64'(sif.out_instr), 64'h00000013);
        chk("first_pc",     sif.out_pc,         64'd0);

        // Backpressure, then release
        sif.out_ready = 1'b0;
        cyc(5);
        chk("bp_imem_frozen", sif.imem_addr, 64'd1);
        sif.out_ready = 1'b1;
        cyc(2);

        // Redirect to 0x40
        redirect(64'h40, 1'b0);
        chk("redir_flush_valid", 64'(sif.out_valid), 64'd0);
        cyc(2);
        chk("redir_valid", 64'(sif.out_valid), 64'd1);
        chk("redir_pc",    sif.out_pc,         64'h40);
        chk("redir_instr", 64'(sif.out_instr), 64'(mem[16]));

        // Run off the end of memory
        redirect(64'h70, 1'b0);
        for (int i = 0; i < 40 && !sif.fault; i++) cyc(1);
        chk("end_fault", 64'(sif.fault), 64'd1);
        cyc(3);
        chk("end_imem_addr", sif.imem_addr, 64'd31);
        pulse_start();
        chk("restart_fault_clr", 64'(sif.fault), 64'd0);
        cyc(4);

        // Misaligned redirect target
        redirect(64'h42, 1'b0);
        cyc(1);
        chk("misalign_fault", 64'(sif.fault), 64'd1);
        pulse_start();
        cyc(3);

        // Redirect together with halt: flush, drain, idle
        redirect(64'h20, 1'b1);
        for (int i = 0; i < 10 && sif.busy; i++) cyc(1);
        chk("halt_redir_idle", 64'(sif.busy), 64'd0);

        // Mid-stream reset with a full queue
        pulse_start();
        cyc(3);
        sif.out_ready = 1'b0;
        cyc(4);
        chk("pre_rst_valid", 64'(sif.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(sif.out_valid), 64'd0);
        chk("midrst_busy",  64'(sif.busy),      64'd0);
        chk("midrst_addr",  sif.imem_addr,      64'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(4);
        chk("postrst_valid", 64'(sif.out_valid), 64'd0);
        sif.out_ready = 1'b1;

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 199);
            s = $urandom_range(0, 9);
            w = $urandom_range(0, DEPTH - 1);
            sif.out_ready      = ($urandom_range(0, 3) != 0);
            sif.start          = (r < 16);
            sif.halt_req       = (r >= 16 && r < 20) || (r == 30);
            sif.redirect_valid = (r >= 20 && r < 31);
            if (s < 8)       sif.redirect_pc = 64'(w) << 2;
            else if (s == 8) sif.redirect_pc = (64'(w) << 2) + 64'($urandom_range(1, 3));
            else             sif.redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0;
            rst_n = (r != 199);
            cyc(1);
        end
        rst_n              = 1'b1;
        sif.start          = 1'b0;
        sif.halt_req       = 1'b0;
        sif.redirect_valid = 1'b0;
        sif.out_ready      = 1'b1;
        cyc(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
